// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side front-end.
package fifo_pkg;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Callers zero-extend g; only the low `width` bits of the result are meaningful.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_skid.sv
// Two-entry skid buffer feeding the FIFO write port; built only when
// FIFO_WR_SKID_EN is defined.
//
// state | meaning
// EMPTY | no word buffered, winc low
// ONE   | head valid, upstream still ready
// TWO   | head and tail valid, upstream stalled
`ifdef FIFO_WR_SKID_EN
module fifo_wr_skid
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE
) (
  input  logic                wclk,
  input  logic                rrst_n,
  input  logic                s_valid,
  input  logic [DATASIZE-1:0] s_data,
  output logic                s_ready,
  input  logic                wfull,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata
);

  skid_state_e         state;
  logic [DATASIZE-1:0] head;
  logic [DATASIZE-1:0] tail;
  logic                push;
  logic                pop;

  assign push  = s_valid & s_ready;
  assign winc  = (state != EMPTY) & ~wfull;
  assign pop   = winc;
  assign wdata = head;

  // s_ready is kept as a flop mirroring (next state != TWO) so it never
  // depends combinationally on s_valid or wfull.
  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state   <= EMPTY;
      head    <= '0;
      tail    <= '0;
      s_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= s_data;
            state <= ONE;
          end
          s_ready <= 1'b1;
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail    <= s_data;
              state   <= TWO;
              s_ready <= 1'b0;
            end
            2'b01: begin
              state   <= EMPTY;
              s_ready <= 1'b1;
            end
            2'b11: begin
              head    <= s_data;
              s_ready <= 1'b1;
            end
            default: s_ready <= 1'b1;
          endcase
        end
        TWO: begin
          if (pop) begin
            head    <= tail;
            state   <= ONE;
            s_ready <= 1'b1;
          end else begin
            s_ready <= 1'b0;
          end
        end
        default: begin
          state   <= EMPTY;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/fifo_wr_stream.sv
// Write-domain stream front-end for the async FIFO: skid buffer (FIFO_WR_SKID_EN)
// or zero-latency pass-through, plus write-side fill level and almost-full.
module fifo_wr_stream
  import fifo_pkg::*;
#(
  parameter int DATASIZE     = DEF_DATASIZE,
  parameter int ADDRSIZE     = DEF_ADDRSIZE,
  parameter int AFULL_THRESH = 56
) (
  input  logic                wclk,
  input  logic                rrst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATASIZE-1:0] s_data,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full
);

  localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] wcnt;
  logic [ADDRSIZE:0] wcnt_next;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_next;

`ifdef FIFO_WR_SKID_EN
  fifo_wr_skid #(
    .DATASIZE(DATASIZE)
  ) u_skid (
    .wclk   (wclk),
    .rrst_n (rrst_n),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .wfull  (wfull),
    .winc   (winc),
    .wdata  (wdata)
  );
`else
  // No storage here, so reset must gate the write strobe and data directly.
  assign s_ready = ~wfull;
  assign winc    = s_valid & ~wfull & rrst_n;
  assign wdata   = rrst_n ? s_data : '0;
`endif

  assign wcnt_next  = wcnt + {{ADDRSIZE{1'b0}}, winc};
  assign rbin       = (ADDRSIZE+1)'(gray2bin(32'(wq2_rptr), ADDRSIZE + 1));
  assign level_next = wcnt_next - rbin;

  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wcnt         <= '0;
      wlevel       <= '0;
      walmost_full <= 1'b0;
    end else begin
      wcnt         <= wcnt_next;
      wlevel       <= level_next;
      walmost_full <= (level_next >= THRESH);
    end
  end

endmodule

// File: tb/tb_fifo_wr_stream.sv
// Directed self-checking bench for fifo_wr_stream; expectations follow the
// build option FIFO_WR_SKID_EN (skid buffer) or the pass-through default.
module tb_fifo_wr_stream;

  logic       wclk = 1'b0;
  logic       rrst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic [6:0] wq2_rptr;
  logic [6:0] wlevel;
  logic       walmost_full;

  int total  = 0;
  int passed = 0;

  fifo_wr_stream dut (
    .wclk        (wclk),
    .rrst_n      (rrst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .winc        (winc),
    .wdata       (wdata),
    .wfull       (wfull),
    .wq2_rptr    (wq2_rptr),
    .wlevel      (wlevel),
    .walmost_full(walmost_full)
  );

  always #5 wclk = ~wclk;

  function automatic logic [6:0] gray7(input int b);
    logic [6:0] v;
    v = 7'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rrst_n  = 1'b0;
    s_valid = 1'b0;
    wfull   = 1'b0;
    cyc();
    rrst_n = 1'b1;
    cyc();
  endtask

  // Pushes n words, optionally trailing the read pointer 4 words behind, then drains.
  task automatic push_n(input int n, input bit track);
    int sent  = 0;
    int guard = 0;
    bit acc;
    while (sent < n && guard < 4 * n + 20) begin
      if (track) wq2_rptr = gray7(sent > 4 ? sent - 4 : 0);
      s_valid = 1'b1;
      s_data  = 8'(sent);
      #1 acc = s_ready;
      cyc();
      guard++;
      if (acc) sent++;
    end
    s_valid = 1'b0;
    total++;
    assert (sent == n) passed++;
    else $error("FAIL push_count: observed %0d expected %0d", sent, n);
    if (track) wq2_rptr = gray7(n - 4);
    repeat (3) cyc();
  endtask

  initial begin
    rrst_n   = 1'b0;
    s_valid  = 1'b1;
    s_data   = 8'h3C;
    wfull    = 1'b0;
    wq2_rptr = '0;
    repeat (2) cyc();
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_afull", walmost_full, 0);
    rrst_n  = 1'b1;
    s_valid = 1'b0;
    cyc();

    // single beat
    s_valid = 1'b1;
    s_data  = 8'hA5;
`ifdef FIFO_WR_SKID_EN
    cyc();
    s_valid = 1'b0;
    #1;
    chk("beat_winc", winc, 1);
    chk("beat_wdata", wdata, 8'hA5);
    chk("beat_s_ready", s_ready, 1);
    cyc();
    #1;
`else
    #1;
    chk("beat_winc", winc, 1);
    chk("beat_wdata", wdata, 8'hA5);
    chk("beat_s_ready", s_ready, 1);
    cyc();
    s_valid = 1'b0;
    #1;
`endif
    chk("beat_winc_off", winc, 0);
    chk("beat_wlevel", wlevel, 1);

    // backpressure
    wfull   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h01;
`ifdef FIFO_WR_SKID_EN
    cyc();
    #1;
    chk("bp_ready_one", s_ready, 1);
    chk("bp_winc_one", winc, 0);
    s_data = 8'h02;
    cyc();
    #1;
    chk("bp_ready_two", s_ready, 0);
    s_data = 8'h03;
    repeat (4) cyc();
    #1;
    chk("bp_ready_hold", s_ready, 0);
    chk("bp_winc_hold", winc, 0);
    wfull = 1'b0;
    #1;
    chk("bp_w1_winc", winc, 1);
    chk("bp_w1_data", wdata, 8'h01);
    chk("bp_w1_ready", s_ready, 0);
    cyc();
    #1;
    chk("bp_w2_winc", winc, 1);
    chk("bp_w2_data", wdata, 8'h02);
    chk("bp_w2_ready", s_ready, 1);
    cyc();
    s_valid = 1'b0;
    #1;
    chk("bp_w3_winc", winc, 1);
    chk("bp_w3_data", wdata, 8'h03);
    cyc();
    #1;
`else
    #1;
    chk("bp_ready_full", s_ready, 0);
    chk("bp_winc_full", winc, 0);
    repeat (6) cyc();
    #1;
    chk("bp_ready_hold", s_ready, 0);
    chk("bp_level_hold", wlevel, 1);
    wfull = 1'b0;
    #1;
    chk("bp_w1_winc", winc, 1);
    chk("bp_w1_data", wdata, 8'h01);
    chk("bp_w1_ready", s_ready, 1);
    cyc();
    s_data = 8'h02;
    #1;
    chk("bp_w2_data", wdata, 8'h02);
    cyc();
    s_data = 8'h03;
    #1;
    chk("bp_w3_data", wdata, 8'h03);
    cyc();
    s_valid = 1'b0;
    #1;
`endif
    chk("bp_winc_off", winc, 0);
    chk("bp_wlevel", wlevel, 4);

    // continuous stream
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + i);
      #1;
`ifdef FIFO_WR_SKID_EN
      if (i > 0) begin
        chk("str_winc", winc, 1);
        chk("str_wdata", wdata, 8'(8'h40 + i - 1));
        chk("str_ready", s_ready, 1);
      end
`else
      chk("str_winc", winc, 1);
      chk("str_wdata", wdata, 8'(8'h40 + i));
`endif
      cyc();
    end
    s_valid = 1'b0;
`ifdef FIFO_WR_SKID_EN
    #1;
    chk("str_last_winc", winc, 1);
    chk("str_last_data", wdata, 8'h53);
    cyc();
`endif
    #1;
    chk("str_winc_off", winc, 0);
    chk("str_wlevel", wlevel, 24);

    // level wrap
    do_reset();
    push_n(130, 1'b1);
    chk("wrap_level", wlevel, 4);
    chk("wrap_afull", walmost_full, 0);
    push_n(60, 1'b0);
    chk("wrap_level64", wlevel, 64);
    chk("wrap_afull64", walmost_full, 1);

    // almost-full threshold
    do_reset();
    wq2_rptr = '0;
    push_n(55, 1'b0);
    chk("af_level55", wlevel, 55);
    chk("af_flag55", walmost_full, 0);
    s_valid = 1'b1;
    s_data  = 8'hEE;
`ifdef FIFO_WR_SKID_EN
    cyc();
    s_valid = 1'b0;
    #1;
    chk("af_winc56", winc, 1);
    chk("af_flag_pre", walmost_full, 0);
    cyc();
    #1;
`else
    #1;
    chk("af_winc56", winc, 1);
    chk("af_flag_pre", walmost_full, 0);
    cyc();
    s_valid = 1'b0;
    #1;
`endif
    chk("af_flag56", walmost_full, 1);
    chk("af_level56", wlevel, 56);

    // asynchronous reset mid-burst
    wfull   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h11;
    cyc();
`ifdef FIFO_WR_SKID_EN
    s_data = 8'h22;
    cyc();
    #1;
    chk("mid_two_ready", s_ready, 0);
`endif
    wfull  = 1'b0;
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_winc", winc, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_level", wlevel, 0);
    chk("mid_rst_afull", walmost_full, 0);
    s_valid = 1'b0;
    cyc();
    rrst_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
